// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   Instruction-decode stage of the 16-bit pipelined core. Splits the fetched
//   instruction into opcode, register operands and immediate. Owns the 8x16
//   register file, whose writeback port bypasses same-cycle reads. Detects
//   load-use hazards and squashes the stage on a taken-branch flush.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   if_valid/if_instr/if_npc   instruction, and its PC+1, from fetch
//   flush               taken branch in Execute, squash the current instruction
//   wb_we/wb_index/wb_data     register-file write port
//   if_stall            combinational, fetch holds its outputs this cycle
//   id_valid, control, source_reg, dest_reg, dest_index, immediate, npc,
//   illegal_op          registered decode results to Execute
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int NREGS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [15:0] if_instr,
    input  logic [15:0] if_npc,
    input  logic        flush,
    input  logic        wb_we,
    input  logic [2:0]  wb_index,
    input  logic [15:0] wb_data,
    output logic        if_stall,
    output logic        id_valid,
    output logic [4:0]  control,
    output logic [15:0] source_reg,
    output logic [15:0] dest_reg,
    output logic [2:0]  dest_index,
    output logic [15:0] immediate,
    output logic [15:0] npc,
    output logic        illegal_op
);

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,  OP_SUB    = 5'd1,  OP_ADDI   = 5'd2,  OP_SHLLI  = 5'd3,
        OP_SHRLI  = 5'd4,  OP_JUMP   = 5'd5,  OP_JUMPLI = 5'd6,  OP_JUMPL  = 5'd7,
        OP_JUMPG  = 5'd8,  OP_JUMPE  = 5'd9,  OP_JUMPNE = 5'd10, OP_CMP    = 5'd11,
        OP_RET    = 5'd12, OP_LOAD   = 5'd13, OP_LOADI  = 5'd14, OP_STORE  = 5'd15,
        OP_MOV    = 5'd16
    } opcode_e;

    // Register file: every entry is reset, so it is built from flops.
    logic [15:0] regs_q [NREGS];

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
            localparam logic [2:0] IDX = 3'(gi);
            always_ff @(posedge clk) begin
                if (reset) begin
                    regs_q[gi] <= '0;
                end else if (wb_we && wb_index == IDX) begin
                    regs_q[gi] <= wb_data;
                end
            end
        end
    endgenerate

    logic [4:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    assign op = if_instr[15:11];
    assign rd = if_instr[10:8];
    assign rs = if_instr[7:5];

    // Read ports with writeback bypass.
    logic [15:0] rs_val;
    logic [15:0] rd_val;
    assign rs_val = (wb_we && wb_index == rs) ? wb_data : regs_q[rs];
    assign rd_val = (wb_we && wb_index == rd) ? wb_data : regs_q[rd];

    // Per-opcode read set and immediate form.
    logic        rs_used;
    logic        rd_used;
    logic        illegal;
    logic [15:0] imm;

    always_comb begin
        rs_used = 1'b0;
        rd_used = 1'b0;
        illegal = 1'b0;
        imm     = '0;
        case (op)
            OP_ADD, OP_SUB, OP_CMP, OP_STORE: begin
                rs_used = 1'b1;
                rd_used = 1'b1;
            end
            OP_ADDI, OP_SHLLI, OP_SHRLI: begin
                rs_used = 1'b1;
                imm     = {11'd0, if_instr[4:0]};
            end
            OP_LOADI: imm = {11'd0, if_instr[4:0]};
            OP_JUMP, OP_JUMPLI, OP_JUMPL, OP_JUMPG, OP_JUMPE, OP_JUMPNE:
                imm = {{5{if_instr[10]}}, if_instr[10:0]};
            OP_LOAD, OP_MOV: rs_used = 1'b1;
            OP_RET: ;
            default: illegal = 1'b1;
        endcase
    end

    // Load-use hazard tracking: set only by an issued LOAD, cleared by
    // anything else, so a stall can never last more than one cycle.
    logic       last_load_q, last_load_d;
    logic [2:0] last_load_idx_q, last_load_idx_d;

    assign if_stall = if_valid && !flush && last_load_q &&
                      ((rs_used && rs == last_load_idx_q) ||
                       (rd_used && rd == last_load_idx_q));

    logic        id_valid_q, id_valid_d;
    logic [4:0]  control_q, control_d;
    logic [15:0] source_q, source_d;
    logic [15:0] dest_q, dest_d;
    logic [2:0]  dest_index_q, dest_index_d;
    logic [15:0] imm_q, imm_d;
    logic [15:0] npc_q, npc_d;
    logic        illegal_q, illegal_d;

    always_comb begin
        // Bubble by default.
        id_valid_d      = 1'b0;
        control_d       = '0;
        source_d        = '0;
        dest_d          = '0;
        dest_index_d    = '0;
        imm_d           = '0;
        npc_d           = '0;
        illegal_d       = 1'b0;
        last_load_d     = 1'b0;
        last_load_idx_d = last_load_idx_q;
        if (if_valid && !flush && !if_stall) begin
            if (illegal) begin
                illegal_d = 1'b1;
            end else begin
                id_valid_d      = 1'b1;
                control_d       = op;
                source_d        = rs_val;
                dest_d          = (op == OP_MOV) ? rs_val : rd_val;
                dest_index_d    = rd;
                imm_d           = imm;
                npc_d           = if_npc;
                last_load_d     = (op == OP_LOAD);
                last_load_idx_d = rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid_q      <= 1'b0;
            control_q       <= '0;
            source_q        <= '0;
            dest_q          <= '0;
            dest_index_q    <= '0;
            imm_q           <= '0;
            npc_q           <= '0;
            illegal_q       <= 1'b0;
            last_load_q     <= 1'b0;
            last_load_idx_q <= '0;
        end else begin
            id_valid_q      <= id_valid_d;
            control_q       <= control_d;
            source_q        <= source_d;
            dest_q          <= dest_d;
            dest_index_q    <= dest_index_d;
            imm_q           <= imm_d;
            npc_q           <= npc_d;
            illegal_q       <= illegal_d;
            last_load_q     <= last_load_d;
            last_load_idx_q <= last_load_idx_d;
        end
    end

    assign id_valid   = id_valid_q;
    assign control    = control_q;
    assign source_reg = source_q;
    assign dest_reg   = dest_q;
    assign dest_index = dest_index_q;
    assign immediate  = imm_q;
    assign npc        = npc_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//   Scoreboard bench for decode_stage. A driver applies one set of inputs per
//   cycle, checks if_stall, and pushes the expected registered outputs
//   produced by a reference model. A monitor pops and compares every cycle.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid = 1'b0;
    logic [15:0] if_instr = '0;
    logic [15:0] if_npc = '0;
    logic        flush = 1'b0;
    logic        wb_we = 1'b0;
    logic [2:0]  wb_index = '0;
    logic [15:0] wb_data = '0;
    logic        if_stall;
    logic        id_valid;
    logic [4:0]  control;
    logic [15:0] source_reg;
    logic [15:0] dest_reg;
    logic [2:0]  dest_index;
    logic [15:0] immediate;
    logic [15:0] npc;
    logic        illegal_op;

    decode_stage #(.NREGS(8)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
        .if_npc(if_npc), .flush(flush), .wb_we(wb_we), .wb_index(wb_index),
        .wb_data(wb_data), .if_stall(if_stall), .id_valid(id_valid),
        .control(control), .source_reg(source_reg), .dest_reg(dest_reg),
        .dest_index(dest_index), .immediate(immediate), .npc(npc),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [4:0]  c;
        logic [15:0] s;
        logic [15:0] d;
        logic [2:0]  di;
        logic [15:0] imm;
        logic [15:0] np;
        logic        ill;
    } out_t;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state.
    int unsigned mregs[8];
    bit          m_ll = 0;
    int          m_ll_idx = 0;
    bit          last_stall = 0;

    function automatic logic [15:0] mk(input int op, input int rd, input int rs, input int lo);
        return 16'((op << 11) | (rd << 8) | (rs << 5) | (lo & 31));
    endfunction

    function automatic logic [15:0] mk_off(input int op, input int off);
        return 16'((op << 11) | (off & 2047));
    endfunction

    // One clock cycle of stimulus plus the model's prediction for it.
    task automatic step(input bit rst, input bit v, input logic [15:0] ins, input logic [15:0] np,
                        input bit fl, input bit we, input int wi, input int wd);
        int op, rd, rs, off, rsv, rdv;
        bit rs_used, rd_used, stall_e;
        out_t e;
        @(negedge clk);
        reset = rst; if_valid = v; if_instr = ins; if_npc = np; flush = fl;
        wb_we = we; wb_index = 3'(wi); wb_data = 16'(wd);
        #1;
        op = int'(ins) / 2048;
        rd = (int'(ins) / 256) % 8;
        rs = (int'(ins) / 32) % 8;
        rs_used = op inside {0, 1, 2, 3, 4, 11, 13, 15, 16};
        rd_used = op inside {0, 1, 11, 15};
        stall_e = v && !fl && m_ll && ((rs_used && rs == m_ll_idx) || (rd_used && rd == m_ll_idx));
        checks++;
        if (if_stall !== stall_e) begin
            errors++;
            $display("FAIL if_stall: got %b expected %b (instr %h)", if_stall, stall_e, ins);
        end
        last_stall = stall_e;
        e = '0;
        if (rst) begin
            foreach (mregs[i]) mregs[i] = 0;
            m_ll = 0;
        end else begin
            rsv = (we && wi == rs) ? wd : int'(mregs[rs]);
            rdv = (we && wi == rd) ? wd : int'(mregs[rd]);
            if (!v || fl || stall_e) begin
                m_ll = 0;
            end else if (op >= 17) begin
                e.ill = 1'b1;
                m_ll = 0;
            end else begin
                e.v  = 1'b1;
                e.c  = 5'(op);
                e.s  = 16'(rsv);
                e.d  = (op == 16) ? 16'(rsv) : 16'(rdv);
                e.di = 3'(rd);
                e.np = np;
                if (op inside {2, 3, 4, 14}) e.imm = 16'(int'(ins) % 32);
                if (op >= 5 && op <= 10) begin
                    off = int'(ins) % 2048;
                    e.imm = (off >= 1024) ? 16'(off + 'hF800) : 16'(off);
                end
                m_ll = (op == 13);
                m_ll_idx = rd;
            end
            if (we) mregs[wi] = 32'(wd & 'hFFFF);
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compare the registered outputs one step after each edge.
    initial begin
        out_t a, e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {id_valid, control, source_reg, dest_reg, dest_index, immediate, npc, illegal_op};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs: got v=%b c=%0d s=%h d=%h di=%0d imm=%h npc=%h ill=%b expected v=%b c=%0d s=%h d=%h di=%0d imm=%h npc=%h ill=%b",
                             a.v, a.c, a.s, a.d, a.di, a.imm, a.np, a.ill,
                             e.v, e.c, e.s, e.d, e.di, e.imm, e.np, e.ill);
                end else begin
                    $display("cycle t=%0t v=%b c=%0d s=%h d=%h di=%0d imm=%h npc=%h ill=%b ok",
                             $time, a.v, a.c, a.s, a.d, a.di, a.imm, a.np, a.ill);
                end
            end
        end
    end

    initial begin
        logic [15:0] ins, np;
        bit v, fl, we, rst;
        int r;
        // Reset, then load R2 and R3.
        step(1, 0, 16'h0, 16'h0, 0, 0, 0, 0);
        step(1, 0, 16'h0, 16'h0, 0, 0, 0, 0);
        step(0, 0, 16'h0, 16'h0, 0, 1, 2, 'h1234);
        step(0, 0, 16'h0, 16'h0, 0, 1, 3, 'h0011);
        step(0, 1, mk(0, 2, 3, 0), 16'h0101, 0, 0, 0, 0);       // ADD rd=2 rs=3
        step(0, 1, mk(16, 1, 5, 0), 16'h0102, 0, 1, 5, 'hBEEF); // MOV with bypass
        step(0, 1, mk(13, 4, 0, 0), 16'h0103, 0, 0, 0, 0);      // LOAD rd=4
        step(0, 1, mk(0, 1, 4, 0), 16'h0104, 0, 0, 0, 0);       // ADD rs=4 stalls
        step(0, 1, mk(0, 1, 4, 0), 16'h0104, 0, 0, 0, 0);       // ADD issues
        step(0, 1, mk(13, 4, 0, 0), 16'h0105, 0, 0, 0, 0);      // LOAD rd=4
        step(0, 1, mk_off(5, 'h404), 16'h0106, 0, 0, 0, 0);     // JUMP, no stall
        step(0, 1, mk_off(10, 'h7FE), 16'h0107, 0, 0, 0, 0);    // JUMPNE -> FFFE
        step(0, 1, mk(2, 1, 1, 'h1F), 16'h0108, 0, 0, 0, 0);    // ADDI -> 001F
        step(0, 1, mk(13, 4, 0, 0), 16'h0109, 0, 0, 0, 0);      // LOAD rd=4
        step(0, 1, mk(0, 1, 4, 0), 16'h010A, 1, 0, 0, 0);       // flush with hazard
        step(0, 1, mk(0, 1, 4, 0), 16'h010A, 0, 0, 0, 0);       // refetch, no stall
        step(0, 1, 16'hFFFF, 16'h010B, 0, 0, 0, 0);             // illegal opcode 31
        step(0, 1, mk(13, 4, 0, 0), 16'h010C, 0, 0, 0, 0);      // LOAD rd=4
        step(1, 1, mk(0, 1, 4, 0), 16'h010D, 0, 1, 6, 'h5555);  // reset during stall
        step(0, 1, mk(16, 1, 6, 0), 16'h010E, 0, 0, 0, 0);      // R6 write discarded

        // Randomised traffic; fetch holds the instruction after a stall.
        ins = '0; np = '0;
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            fl  = ($urandom_range(0, 99) < 8);
            we  = ($urandom_range(0, 99) < 50);
            if (last_stall) begin
                v = 1;
            end else begin
                v = ($urandom_range(0, 99) < 90);
                r = $urandom_range(0, 99);
                if (r < 25)      ins = mk(13, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
                else if (r < 30) ins = mk($urandom_range(17, 31), $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
                else             ins = 16'(mk($urandom_range(0, 16), $urandom_range(0, 3), $urandom_range(0, 3), 0) | ($urandom & 31));
                if ((ins >> 11) >= 5 && (ins >> 11) <= 10 && $urandom_range(0, 1) == 1) ins = mk_off(int'(ins >> 11), $urandom);
                np = 16'($urandom);
            end
            step(rst, v, ins, np, fl, we, $urandom_range(0, 7), $urandom);
        end
        step(0, 0, 16'h0, 16'h0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
